// File: rtl/cache_parameters.sv
// Shared cache/memory transaction types: one request or response carries a whole 128-bit block.
package cache_parameters;

    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned BLOCK_WIDTH = 128;

    typedef struct packed {
        logic                   cs;
        logic                   rw;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [BLOCK_WIDTH-1:0] data;
    } memory_request_t;

    typedef struct packed {
        logic                   ack;
        logic [BLOCK_WIDTH-1:0] data;
    } memory_response_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory block port between the icache (owner 0) and the dcache (owner 1),
// holding each grant until ack, requester abort or watchdog timeout.
module mem_port_arbiter
    import cache_parameters::*;
#(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  memory_request_t  i_req,
    input  memory_request_t  d_req,
    output memory_response_t i_res,
    output memory_response_t d_res,
    output memory_request_t  mem_req,
    input  memory_response_t mem_res,
    output logic [1:0]       grant,
    output logic             timeout_err
);

    localparam int unsigned CntWidth = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Counter holds k-1 during the k-th BUSY cycle, so the abort fires on this value.
    localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StRelease
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic                  r_owner;
    logic                  w_owner_next;
    logic                  r_grant_valid;
    logic                  r_last_owner;
    logic [CntWidth-1:0]   r_cnt;
    logic                  r_timeout;
    logic                  w_timeout;
    memory_request_t       w_owner_req;

    assign w_owner_req = r_owner ? d_req : i_req;

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_timeout    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_req.cs || d_req.cs) begin
                    w_state_next = StBusy;
                    if (i_req.cs && d_req.cs) begin
                        w_owner_next = (PRIORITY_MODE != 0) ? 1'b1 : ~r_last_owner;
                    end else begin
                        w_owner_next = d_req.cs;
                    end
                end
            end
            StBusy: begin
                if (mem_res.ack) begin
                    w_state_next = StRelease;
                end else if (!w_owner_req.cs) begin
                    w_state_next = StRelease;
                end else if ((TIMEOUT_CYCLES != 0) && (r_cnt == TimeoutLast)) begin
                    w_state_next = StRelease;
                    w_timeout    = 1'b1;
                end
            end
            StRelease: w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_owner       <= 1'b0;
            r_grant_valid <= 1'b0;
            r_last_owner  <= 1'b0;
            r_cnt         <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_owner       <= w_owner_next;
            r_grant_valid <= (w_state_next == StBusy);
            r_timeout     <= w_timeout;
            if (r_state == StRelease) begin
                r_last_owner <= r_owner;
            end
            if (r_state == StIdle) begin
                r_cnt <= '0;
            end else if (r_state == StBusy) begin
                r_cnt <= r_cnt + CntWidth'(1);
            end
        end
    end

    // Reset forces every output low so memory sees cs drop in the reset cycle itself.
    always_comb begin
        mem_req     = '0;
        i_res       = '0;
        d_res       = '0;
        grant       = 2'b00;
        timeout_err = 1'b0;
        if (!rst) begin
            i_res.data  = mem_res.data;
            d_res.data  = mem_res.data;
            timeout_err = r_timeout;
            if (r_state == StBusy) begin
                mem_req = w_owner_req;
                if (r_owner) begin
                    d_res.ack = mem_res.ack;
                end else begin
                    i_res.ack = mem_res.ack;
                end
            end
            if (r_grant_valid) begin
                grant = r_owner ? 2'b10 : 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin/watchdog instance (TIMEOUT_CYCLES=8) and a fixed-priority instance.
module tb_mem_port_arbiter;
    import cache_parameters::*;

    typedef logic [191:0] val_t;

    localparam logic [127:0] Pat = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [127:0] Wb  = {4{32'hA5A5_A5A5}};

    logic             clk;
    logic             rst;
    memory_request_t  i_req, d_req, mem_req;
    memory_response_t i_res, d_res, mem_res;
    logic [1:0]       grant;
    logic             timeout_err;

    memory_request_t  f_i_req, f_d_req, f_mem_req;
    memory_response_t f_i_res, f_d_res, f_mem_res;
    logic [1:0]       f_grant;
    logic             f_timeout_err;

    int n_checks;
    int n_errors;
    logic exp_d;
    memory_request_t i_rd, d_rd, d_wb;

    mem_port_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) u_dut (
        .clk(clk), .rst(rst), .i_req(i_req), .d_req(d_req), .i_res(i_res), .d_res(d_res),
        .mem_req(mem_req), .mem_res(mem_res), .grant(grant), .timeout_err(timeout_err)
    );

    mem_port_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) u_dut_fp (
        .clk(clk), .rst(rst), .i_req(f_i_req), .d_req(f_d_req), .i_res(f_i_res),
        .d_res(f_d_res), .mem_req(f_mem_req), .mem_res(f_mem_res), .grant(f_grant),
        .timeout_err(f_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input val_t obs, input val_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic memory_request_t mk_req(input logic cs, input logic rw,
                                               input logic [31:0] addr, input logic [127:0] data);
        memory_request_t r;
        r.cs   = cs;
        r.rw   = rw;
        r.addr = addr;
        r.data = data;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        i_req   = '0;
        d_req   = '0;
        mem_res = '0;
        f_i_req = '0;
        f_d_req = '0;
        f_mem_res = '0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        clear_inputs();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_inputs();
        i_rd = mk_req(1'b1, 1'b0, 32'h0000_0100, '0);
        d_rd = mk_req(1'b1, 1'b0, 32'h0000_3000, '0);
        d_wb = mk_req(1'b1, 1'b1, 32'h0000_2040, Wb);

        // Reset: outputs forced to zero even with live inputs.
        tick();
        i_req = i_rd;
        mem_res.ack = 1'b1;
        mem_res.data = Pat;
        #1;
        check("rst_grant", val_t'(grant), val_t'(2'b00));
        check("rst_mem_req", val_t'(mem_req), val_t'(0));
        check("rst_i_res", val_t'(i_res), val_t'(0));
        check("rst_d_res", val_t'(d_res), val_t'(0));
        check("rst_tmo", val_t'(timeout_err), val_t'(1'b0));
        do_reset();

        // Lone icache read, ack on the 4th BUSY cycle.
        tick();
        i_req = i_rd;
        #1;
        check("lone_idle_cs", val_t'(mem_req.cs), val_t'(1'b0));
        check("lone_idle_grant", val_t'(grant), val_t'(2'b00));
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) begin
                mem_res.ack = 1'b1;
                mem_res.data = Pat;
            end
            #1;
            check("lone_mem_req", val_t'(mem_req), val_t'(i_rd));
            check("lone_grant", val_t'(grant), val_t'(2'b01));
            check("lone_i_ack", val_t'(i_res.ack), val_t'(k == 4));
            check("lone_d_ack", val_t'(d_res.ack), val_t'(1'b0));
        end
        check("lone_i_data", val_t'(i_res.data), val_t'(Pat));
        check("lone_d_data", val_t'(d_res.data), val_t'(Pat));
        tick();
        i_req = '0;
        mem_res = '0;
        #1;
        check("lone_rel_cs", val_t'(mem_req.cs), val_t'(1'b0));
        check("lone_rel_grant", val_t'(grant), val_t'(2'b00));
        check("lone_rel_ack", val_t'(i_res.ack), val_t'(1'b0));

        // Round-robin with both requesting: d, i, d, i after reset.
        do_reset();
        for (int t = 0; t < 4; t++) begin
            exp_d = (t % 2 == 0);
            tick();
            i_req = i_rd;
            d_req = d_rd;
            #1;
            check("rr_idle_cs", val_t'(mem_req.cs), val_t'(1'b0));
            tick();
            #1;
            check("rr_grant", val_t'(grant), val_t'(exp_d ? 2'b10 : 2'b01));
            check("rr_mem_req", val_t'(mem_req), val_t'(exp_d ? d_rd : i_rd));
            tick();
            mem_res.ack = 1'b1;
            #1;
            check("rr_d_ack", val_t'(d_res.ack), val_t'(exp_d));
            check("rr_i_ack", val_t'(i_res.ack), val_t'(!exp_d));
            tick();
            mem_res.ack = 1'b0;
            #1;
            check("rr_rel_cs", val_t'(mem_req.cs), val_t'(1'b0));
            check("rr_rel_grant", val_t'(grant), val_t'(2'b00));
        end

        // Dcache write-back, ack on the 3rd BUSY cycle.
        do_reset();
        tick();
        d_req = d_wb;
        #1;
        check("wb_idle_cs", val_t'(mem_req.cs), val_t'(1'b0));
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 3) mem_res.ack = 1'b1;
            #1;
            check("wb_mem_req", val_t'(mem_req), val_t'(d_wb));
            check("wb_grant", val_t'(grant), val_t'(2'b10));
            check("wb_d_ack", val_t'(d_res.ack), val_t'(k == 3));
        end
        tick();
        d_req = '0;
        mem_res = '0;
        #1;
        check("wb_rel_cs", val_t'(mem_req.cs), val_t'(1'b0));

        // Watchdog: 8 BUSY cycles, abort, pulse in RELEASE, then re-grant.
        do_reset();
        tick();
        i_req = i_rd;
        #1;
        check("wd_idle_grant", val_t'(grant), val_t'(2'b00));
        for (int k = 1; k <= 8; k++) begin
            tick();
            #1;
            check("wd_busy_grant", val_t'(grant), val_t'(2'b01));
            check("wd_busy_tmo", val_t'(timeout_err), val_t'(1'b0));
            check("wd_busy_ack", val_t'({i_res.ack, d_res.ack}), val_t'(2'b00));
        end
        tick();
        #1;
        check("wd_rel_tmo", val_t'(timeout_err), val_t'(1'b1));
        check("wd_rel_cs", val_t'(mem_req.cs), val_t'(1'b0));
        check("wd_rel_ack", val_t'({i_res.ack, d_res.ack}), val_t'(2'b00));
        tick();
        #1;
        check("wd_idle_tmo", val_t'(timeout_err), val_t'(1'b0));
        check("wd_idle2_grant", val_t'(grant), val_t'(2'b00));
        tick();
        #1;
        check("wd_regrant", val_t'(grant), val_t'(2'b01));
        check("wd_regrant_req", val_t'(mem_req), val_t'(i_rd));
        tick();
        i_req = '0;
        #1;
        check("wd_abort_cs", val_t'(mem_req.cs), val_t'(1'b0));
        tick();
        #1;
        check("wd_abort_tmo", val_t'(timeout_err), val_t'(1'b0));

        // Reset on the 2nd BUSY cycle of a dcache grant.
        do_reset();
        tick();
        i_req = i_rd;
        d_req = d_rd;
        tick();
        #1;
        check("mr_busy1_grant", val_t'(grant), val_t'(2'b10));
        tick();
        rst = 1'b1;
        mem_res.ack = 1'b1;
        #1;
        check("mr_rst_cs", val_t'(mem_req.cs), val_t'(1'b0));
        check("mr_rst_grant", val_t'(grant), val_t'(2'b00));
        check("mr_rst_ack", val_t'({i_res.ack, d_res.ack}), val_t'(2'b00));
        tick();
        rst = 1'b0;
        mem_res.ack = 1'b0;
        #1;
        check("mr_idle_grant", val_t'(grant), val_t'(2'b00));
        tick();
        #1;
        check("mr_regrant", val_t'(grant), val_t'(2'b10));
        check("mr_regrant_req", val_t'(mem_req), val_t'(d_rd));

        // Fixed priority: dcache wins while it keeps requesting.
        do_reset();
        for (int t = 0; t < 3; t++) begin
            tick();
            f_i_req = i_rd;
            f_d_req = d_rd;
            #1;
            check("fp_idle_grant", val_t'(f_grant), val_t'(2'b00));
            tick();
            f_mem_res.ack = 1'b1;
            #1;
            check("fp_grant", val_t'(f_grant), val_t'(2'b10));
            check("fp_d_ack", val_t'(f_d_res.ack), val_t'(1'b1));
            check("fp_i_ack", val_t'(f_i_res.ack), val_t'(1'b0));
            tick();
            f_mem_res.ack = 1'b0;
            #1;
            check("fp_rel_cs", val_t'(f_mem_req.cs), val_t'(1'b0));
        end
        tick();
        f_d_req = '0;
        #1;
        check("fp_idle_nod", val_t'(f_grant), val_t'(2'b00));
        tick();
        #1;
        check("fp_i_grant", val_t'(f_grant), val_t'(2'b01));
        check("fp_i_req", val_t'(f_mem_req), val_t'(i_rd));

        do_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
